rec_event_encoder: RTL and testbench

Front-end command encoder for the recorder. Synchronises and debounces the four DE2-115 pushbuttons and the playback-mode switches, runs the user-level transport state machine, and emits one-cycle 16-bit command words. These words are consumed by the time core, the SRAM recorder and the audio player. It is the producing end of the `input_event` bus: opcode in bits [15:12], arguments below.

---
 rtl/recorder_pkg.sv | 46 ++++
 rtl/input_debouncer.sv | 66 ++++++
 rtl/rec_event_encoder.sv | 105 ++++++++++
 tb/tb_rec_event_encoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/recorder_pkg.sv
// Shared recorder definitions: command opcodes, transport states and the
// layout of the 16-bit input_event word.
package recorder_pkg;

   localparam logic [3:0] REC_NONE   = 4'd0;
   localparam logic [3:0] REC_RECORD = 4'd1;
   localparam logic [3:0] REC_PAUSE  = 4'd2;
   localparam logic [3:0] REC_STOP   = 4'd3;
   localparam logic [3:0] REC_PLAY   = 4'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RECORD = 3'd1,
      ST_PAUSE  = 3'd2,
      ST_STOP   = 3'd3,
      ST_PLAY   = 3'd4
   } rec_state_e;

   localparam int unsigned EV_OPC_LSB    = 12;
   localparam int unsigned EV_SPEED_LSB  = 8;
   localparam int unsigned EV_SLOW_BIT   = 7;
   localparam int unsigned EV_INTERP_BIT = 6;

   localparam logic [3:0] SPEED_MIN = 4'd1;
   localparam logic [3:0] SPEED_MAX = 4'd8;

   function automatic logic [3:0] clamp_speed(input logic [3:0] spd);
      if (spd < SPEED_MIN)      return SPEED_MIN;
      else if (spd > SPEED_MAX) return SPEED_MAX;
      else                      return spd;
   endfunction

   function automatic logic [15:0] make_event(input logic [3:0] opc,
                                              input logic [3:0] spd,
                                              input logic       slow,
                                              input logic       interp);
      logic [15:0] w;
      w = '0;
      w[EV_OPC_LSB +: 4]   = opc;
      w[EV_SPEED_LSB +: 4] = spd;
      w[EV_SLOW_BIT]       = slow;
      w[EV_INTERP_BIT]     = interp;
      return w;
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// Single-bit 2-flop synchroniser plus stability counter. The counter is only
// built when REC_EVENT_DEBOUNCE_EN is defined; otherwise the synced value passes through.
module input_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter logic        IDLE_VAL        = 1'b0,
   parameter bit          HOLD_UNTIL_IDLE = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_raw,
   output logic o_stable
);

   logic [1:0] sync_q;
   logic [1:0] fill_q;
   logic       arm_q;
   logic       synced;

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'h00FF_FFFF) begin : g_bad_cfg
      $error("input_debouncer: DEBOUNCE_CYCLES out of range");
   end

   // An input held away from its idle level through reset stays masked until
   // it has been seen at idle once the synchroniser holds real samples.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= {2{IDLE_VAL}};
         fill_q <= '0;
         arm_q  <= ~HOLD_UNTIL_IDLE;
      end else begin
         sync_q <= {sync_q[0], i_raw};
         fill_q <= {fill_q[0], 1'b1};
         if (fill_q[1] && (sync_q[1] == IDLE_VAL)) arm_q <= 1'b1;
      end
   end

   assign synced = arm_q ? sync_q[1] : IDLE_VAL;

`ifdef REC_EVENT_DEBOUNCE_EN
   localparam logic [23:0] CNT_MAX = 24'(DEBOUNCE_CYCLES - 1);

   logic [23:0] cnt_q;
   logic        stable_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q    <= '0;
         stable_q <= IDLE_VAL;
      end else if (synced != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_q <= synced;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 24'd1;
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign o_stable = stable_q;
`else
   assign o_stable = synced;
`endif

endmodule

// File: rtl/rec_event_encoder.sv
// Recorder front end: debounced keys/switches, transport FSM and one-cycle
// input_event command words. Debouncing is enabled by REC_EVENT_DEBOUNCE_EN.
module rec_event_encoder
   import recorder_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_key,
   input  logic [5:0]  i_sw,
   input  logic        i_play_done,
   output logic [15:0] o_input_event,
   output logic [2:0]  o_state
);

   logic [3:0]  key_db;
   logic [5:0]  sw_db;
   logic [3:0]  key_q;
   logic [5:0]  sw_q;
   logic        done_q;
   logic        pfp_q;
   logic [15:0] event_q;
   rec_state_e  state_q;

   logic [3:0]  press;
   logic        in_play;
   logic        stop_v, pause_v, rec_v, play_v, sw_v;
   logic [15:0] play_word;

   for (genvar g = 0; g < 4; g++) begin : g_key
      input_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_VAL        (1'b1),
         .HOLD_UNTIL_IDLE (1'b1)
      ) u_db (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_raw    (i_key[g]),
         .o_stable (key_db[g])
      );
   end

   for (genvar g = 0; g < 6; g++) begin : g_sw
      input_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_VAL        (1'b0),
         .HOLD_UNTIL_IDLE (1'b0)
      ) u_db (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_raw    (i_sw[g]),
         .o_stable (sw_db[g])
      );
   end

   assign press   = key_q & ~key_db;
   assign in_play = (state_q == ST_PLAY);

   assign stop_v  = (press[3] && (state_q inside {ST_RECORD, ST_PLAY, ST_PAUSE}))
                 || (done_q && in_play);
   assign pause_v = press[2] && (state_q inside {ST_RECORD, ST_PLAY});
   assign rec_v   = press[0] && ((state_q inside {ST_IDLE, ST_STOP})
                                 || ((state_q == ST_PAUSE) && !pfp_q));
   assign play_v  = press[1] && ((state_q == ST_STOP)
                                 || ((state_q == ST_PAUSE) && pfp_q));
   assign sw_v    = in_play && (sw_db != sw_q);

   assign play_word = make_event(REC_PLAY, clamp_speed(sw_db[3:0]), sw_db[4], sw_db[5]);

   // if/else chain encodes the arbitration order; losing requests are dropped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         event_q <= '0;
         pfp_q   <= 1'b0;
         key_q   <= '1;
         sw_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         key_q   <= key_db;
         sw_q    <= sw_db;
         done_q  <= i_play_done;
         event_q <= make_event(REC_NONE, '0, 1'b0, 1'b0);
         if (stop_v) begin
            state_q <= ST_STOP;
            event_q <= make_event(REC_STOP, '0, 1'b0, 1'b0);
         end else if (pause_v) begin
            state_q <= ST_PAUSE;
            pfp_q   <= in_play;
            event_q <= make_event(REC_PAUSE, '0, 1'b0, 1'b0);
         end else if (rec_v) begin
            state_q <= ST_RECORD;
            event_q <= make_event(REC_RECORD, '0, 1'b0, 1'b0);
         end else if (play_v || sw_v) begin
            state_q <= ST_PLAY;
            event_q <= play_word;
         end
      end
   end

   assign o_input_event = event_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_rec_event_encoder.sv
// Directed bench for rec_event_encoder with DEBOUNCE_CYCLES=4; expected latency
// follows whether REC_EVENT_DEBOUNCE_EN is defined.
module tb_rec_event_encoder;

`ifdef REC_EVENT_DEBOUNCE_EN
   localparam int LAT = 6;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  key;
   logic [5:0]  sw;
   logic        play_done;
   logic [15:0] ev;
   logic [2:0]  st;

   int n_assert = 0;
   int n_fail   = 0;

   rec_event_encoder #(.DEBOUNCE_CYCLES(4)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_key         (key),
      .i_sw          (sw),
      .i_play_done   (play_done),
      .o_input_event (ev),
      .o_state       (st)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Samples #1 after each of the next n edges; reports event count, first word and its edge index.
   task automatic window(input int n, output int cnt, output logic [15:0] first, output int at);
      cnt = 0; first = '0; at = -1;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); #1;
         if (ev !== 16'h0000) begin
            if (cnt == 0) begin first = ev; at = i; end
            cnt++;
         end
      end
   endtask

   task automatic expect_evt(input string tag, input logic [15:0] w, input logic [2:0] s);
      int cnt, at;
      logic [15:0] f;
      window(LAT + 6, cnt, f, at);
      check({tag, " count"}, 16'(cnt), (w == 16'h0) ? 16'd0 : 16'd1);
      if (w != 16'h0) begin
         check({tag, " word"}, f, w);
         check({tag, " latency"}, 16'(at), 16'(LAT + 1));
      end
      check({tag, " state"}, {13'b0, st}, {13'b0, s});
   endtask

   task automatic press(input int n, input string tag, input logic [15:0] w, input logic [2:0] s);
      @(posedge clk); #1;
      key[n] = 1'b0;
      expect_evt(tag, w, s);
      key[n] = 1'b1;
      expect_evt({tag, " release"}, 16'h0, s);
   endtask

   task automatic set_sw(input logic [5:0] v, input string tag, input logic [15:0] w, input logic [2:0] s);
      @(posedge clk); #1;
      sw = v;
      expect_evt(tag, w, s);
   endtask

   initial begin
      int          cnt, at;
      logic [15:0] f;

      rst_n = 1'b0; key = 4'hF; sw = 6'b0; play_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset event", ev, 16'h0000);
      check("reset state", {13'b0, st}, 16'd0);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

`ifdef REC_EVENT_DEBOUNCE_EN
      key[0] = 1'b0; repeat (3) @(posedge clk); #1;
      key[0] = 1'b1; @(posedge clk); #1;
      key[0] = 1'b0; repeat (2) @(posedge clk); #1;
      key[0] = 1'b1;
      window(16, cnt, f, at);
      check("glitch count", 16'(cnt), 16'd0);
      check("glitch state", {13'b0, st}, 16'd0);
`endif

      press(0, "record", 16'h1000, 3'd1);
      press(3, "stop", 16'h3000, 3'd3);
      set_sw(6'b110000, "sw in stop", 16'h0000, 3'd3);
      press(1, "play", 16'h41C0, 3'd4);
      press(2, "pause", 16'h2000, 3'd2);
      press(0, "rec in pause", 16'h0000, 3'd2);
      press(1, "resume", 16'h41C0, 3'd4);
      set_sw(6'b111111, "speed F", 16'h48C0, 3'd4);
      set_sw(6'b001000, "speed 8", 16'h4800, 3'd4);
      set_sw(6'b000111, "speed 7", 16'h4700, 3'd4);
      set_sw(6'b000000, "speed 0", 16'h4100, 3'd4);

      // play press and play_done reach the arbiter in the same cycle
      @(posedge clk); #1;
      key[1] = 1'b0;
      repeat (LAT - 1) @(posedge clk);
      #1;
      play_done = 1'b1;
      @(posedge clk); #1;
      play_done = 1'b0;
      window(LAT + 6, cnt, f, at);
      check("done+play count", 16'(cnt), 16'd1);
      check("done+play word", f, 16'h3000);
      check("done+play latency", 16'(at), 16'd1);
      check("done+play state", {13'b0, st}, 16'd3);
      key[1] = 1'b1;
      expect_evt("done+play release", 16'h0000, 3'd3);

      @(posedge clk); #1;
      play_done = 1'b1;
      @(posedge clk); #1;
      play_done = 1'b0;
      expect_evt("done in stop", 16'h0000, 3'd3);

      press(0, "record 2", 16'h1000, 3'd1);
      @(posedge clk); #1;
      key[3] = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async rst event", ev, 16'h0000);
      check("async rst state", {13'b0, st}, 16'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_evt("held stop", 16'h0000, 3'd0);
      key[3] = 1'b1;
      expect_evt("held stop release", 16'h0000, 3'd0);
      press(3, "stop in idle", 16'h0000, 3'd0);
      press(0, "record after rst", 16'h1000, 3'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no end of test, expected completion");
      $fatal(1, "timeout");
   end

endmodule
